// File: rtl/imem_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_responder_pkg : shared widths, FSM encoding and fill-kind constants
// Rev 1.0
// ----------------------------------------------------------------------------
package imem_responder_pkg;

  localparam int ADDR_W       = 16;
  localparam int HW_W         = 16;
  localparam int WORD_W       = 2 * HW_W;
  localparam int IBUF_ENTRIES = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  localparam logic KIND_DEMAND   = 1'b0;
  localparam logic KIND_PREFETCH = 1'b1;

endpackage
`default_nettype wire

// File: rtl/imem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_responder_if : fetch-stage and backing-memory signals of the responder
// Rev 1.0
// ----------------------------------------------------------------------------
interface imem_responder_if #(
  parameter int ADDR = 16,
  parameter int HW   = 16
);
  logic [ADDR-1:0] fetch_addr_i;
  logic [2*HW-1:0] inst_o;
  logic            stall_o;
  logic            mem_req_o;
  logic [ADDR:0]   mem_addr_o;
  logic            mem_ack_i;
  logic [HW-1:0]   mem_rdata_i;

  modport slave (
    input  fetch_addr_i, mem_ack_i, mem_rdata_i,
    output inst_o, stall_o, mem_req_o, mem_addr_o
  );

  // Fetch stage and backing memory seen together as the environment
  modport master (
    output fetch_addr_i, mem_ack_i, mem_rdata_i,
    input  inst_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface
`default_nettype wire

// File: rtl/imem_responder_ibuf_entry.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_ibuf_entry : one instruction-buffer entry (valid/tag/data) with compare
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_ibuf_entry
  import imem_responder_pkg::*;
#(
  parameter int ADDR = ADDR_W,
  parameter int WORD = WORD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [ADDR-1:0] wtag_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [ADDR-1:0] cmp_tag_i,
  output logic            valid_o,
  output logic [ADDR-1:0] tag_o,
  output logic [WORD-1:0] data_o,
  output logic            match_o
);

  logic            valid_q, valid_d;
  logic [ADDR-1:0] tag_q,   tag_d;
  logic [WORD-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we_i) begin
      valid_d = 1'b1;
      tag_d   = wtag_i;
      data_d  = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;
  assign match_o = valid_q && (tag_q == cmp_tag_i);

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_responder : 2-entry instruction buffer with halfword refill and prefetch
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR = ADDR_W,
  parameter int HW   = HW_W,
  parameter int WORD = 2 * HW
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_responder_if.slave       bus
);

  logic [1:0]      state_q,     state_d;
  logic [ADDR-1:0] fill_addr_q, fill_addr_d;
  logic            kind_q,      kind_d;
  logic [HW-1:0]   lo_q,        lo_d;
  logic            mem_req_q,   mem_req_d;
  logic [ADDR:0]   mem_addr_q,  mem_addr_d;
  logic            cur_q,       cur_d;

  logic [IBUF_ENTRIES-1:0] ent_valid;
  logic [IBUF_ENTRIES-1:0] ent_match;
  logic [IBUF_ENTRIES-1:0] ent_we;
  logic [ADDR-1:0]         ent_tag  [IBUF_ENTRIES];
  logic [WORD-1:0]         ent_data [IBUF_ENTRIES];

  logic            hit;
  logic            hit_idx;
  logic [WORD-1:0] inst;
  logic [ADDR-1:0] next_addr;
  logic            next_present;
  logic            fill_present;
  logic            victim;

  generate
    for (genvar gi = 0; gi < IBUF_ENTRIES; gi++) begin : g_entry
      imem_ibuf_entry #(.ADDR(ADDR), .WORD(WORD)) u_entry (
        .clk       (clk),
        .rst       (rst),
        .we_i      (ent_we[gi]),
        .wtag_i    (fill_addr_q),
        .wdata_i   ({bus.mem_rdata_i, lo_q}),
        .cmp_tag_i (bus.fetch_addr_i),
        .valid_o   (ent_valid[gi]),
        .tag_o     (ent_tag[gi]),
        .data_o    (ent_data[gi]),
        .match_o   (ent_match[gi])
      );
    end
  endgenerate

  assign next_addr = bus.fetch_addr_i + ADDR'(1);
  assign victim    = ~cur_q;

  // Tags are unique, so at most one entry matches any address
  always_comb begin
    hit          = 1'b0;
    hit_idx      = 1'b0;
    inst         = '0;
    next_present = 1'b0;
    fill_present = 1'b0;
    for (int i = 0; i < IBUF_ENTRIES; i++) begin
      if (ent_match[i]) begin
        hit     = 1'b1;
        hit_idx = 1'(i);
        inst    = ent_data[i];
      end
      if (ent_valid[i] && (ent_tag[i] == next_addr))   next_present = 1'b1;
      if (ent_valid[i] && (ent_tag[i] == fill_addr_q)) fill_present = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    kind_d      = kind_q;
    lo_d        = lo_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cur_d       = hit ? hit_idx : cur_q;
    ent_we      = '0;
    case (state_q)
      ST_IDLE: begin
        if (!hit) begin
          fill_addr_d = bus.fetch_addr_i;
          kind_d      = KIND_DEMAND;
          state_d     = ST_LO;
          mem_req_d   = 1'b1;
          mem_addr_d  = {bus.fetch_addr_i, 1'b0};
        end else if (!next_present) begin
          fill_addr_d = next_addr;
          kind_d      = KIND_PREFETCH;
          state_d     = ST_LO;
          mem_req_d   = 1'b1;
          mem_addr_d  = {next_addr, 1'b0};
        end
      end
      ST_LO: begin
        if (bus.mem_ack_i) begin
          lo_d = bus.mem_rdata_i;
          // A prefetch made useless by a branch is dropped after its LO beat
          if ((kind_q == KIND_PREFETCH) && !hit && (bus.fetch_addr_i != fill_addr_q)) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d    = ST_HI;
            mem_addr_d = {fill_addr_q, 1'b1};
          end
        end
      end
      ST_HI: begin
        if (bus.mem_ack_i) begin
          for (int i = 0; i < IBUF_ENTRIES; i++) begin
            ent_we[i] = !fill_present && (1'(i) == victim);
          end
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fill_addr_q <= '0;
      kind_q      <= KIND_DEMAND;
      lo_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      cur_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      kind_q      <= kind_d;
      lo_q        <= lo_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cur_q       <= cur_d;
    end
  end

  assign bus.inst_o     = inst;
  assign bus.stall_o    = ~hit;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_responder : directed checks of the instruction-fetch responder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_responder_if #(.ADDR(16), .HW(16)) bus ();

  imem_responder #(.ADDR(16), .HW(16), .WORD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec     = 0;
  int n_err     = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  // Backing memory: low half = 0x1111^word, high half = 0x2222^word
  function automatic logic [15:0] mem_half(input logic [16:0] ha);
    return ha[0] ? (16'h2222 ^ ha[16:1]) : (16'h1111 ^ ha[16:1]);
  endfunction

  function automatic logic [31:0] exp_word(input logic [15:0] a);
    return {16'h2222 ^ a, 16'h1111 ^ a};
  endfunction

  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
  end

  always @(negedge clk) begin
    if (!rst || !bus.mem_req_o) begin
      wait_cnt      = 0;
      bus.mem_ack_i = 1'b0;
    end else if (wait_cnt >= ack_delay) begin
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = mem_half(bus.mem_addr_o);
      wait_cnt        = 0;
    end else begin
      bus.mem_ack_i = 1'b0;
      wait_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] a);
    rst              = 1'b0;
    bus.fetch_addr_i = a;
    ack_delay        = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Leaves the bench at the sample point of the first non-stalled cycle
  task automatic wait_hit(output int stalls);
    bit done;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      samp();
      if (!bus.stall_o) done = 1'b1;
      else begin
        stalls++;
        next_cyc();
      end
    end
    if (!done) chk("wait_hit timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int st;
    logic        prev_req, prev_ack, done;
    logic [16:0] prev_addr;

    // 1: reset state and first demand fill
    bus.fetch_addr_i = 16'h0000;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    samp();
    chk("t1 rst stall", bus.stall_o, 1);
    chk("t1 rst inst", bus.inst_o, 0);
    chk("t1 rst req", bus.mem_req_o, 0);
    chk("t1 rst addr", bus.mem_addr_o, 0);
    next_cyc(); rst = 1'b1;
    samp();
    chk("t1 N stall", bus.stall_o, 1);
    chk("t1 N req", bus.mem_req_o, 0);
    next_cyc(); samp();
    chk("t1 N+1 req", bus.mem_req_o, 1);
    chk("t1 N+1 addr", bus.mem_addr_o, 17'h00000);
    chk("t1 N+1 stall", bus.stall_o, 1);
    next_cyc(); samp();
    chk("t1 N+2 addr", bus.mem_addr_o, 17'h00001);
    chk("t1 N+2 stall", bus.stall_o, 1);
    next_cyc(); samp();
    chk("t1 N+3 stall", bus.stall_o, 0);
    chk("t1 N+3 inst", bus.inst_o, 32'h22221111);

    // 2: sequential fetch covered by prefetch
    do_reset(16'h0000);
    wait_hit(st);
    chk("t2 first stalls", st, 3);
    for (int n = 1; n <= 3; n++) begin
      repeat (3) next_cyc();
      bus.fetch_addr_i = 16'(n);
      samp();
      chk("t2 seq stall", bus.stall_o, 0);
      chk("t2 seq inst", bus.inst_o, exp_word(16'(n)));
    end

    // 3: four-cycle ack latency per halfword
    do_reset(16'h0005);
    ack_delay = 3;
    st = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      samp();
      if (prev_req && !prev_ack) begin
        chk("t3 req held", bus.mem_req_o, 1);
        chk("t3 addr held", bus.mem_addr_o, prev_addr);
      end
      if (!bus.stall_o) done = 1'b1;
      else st++;
      prev_req  = bus.mem_req_o;
      prev_ack  = bus.mem_ack_i;
      prev_addr = bus.mem_addr_o;
      if (!done) next_cyc();
    end
    chk("t3 stalls", st, 9);
    chk("t3 inst", bus.inst_o, 32'h22271114);

    // 4: branch away while prefetch of 0x0011 is in LO
    do_reset(16'h0010);
    wait_hit(st);
    chk("t4 0x10 inst", bus.inst_o, 32'h22321101);
    ack_delay = 2;
    next_cyc(); bus.fetch_addr_i = 16'h0800; samp();
    chk("t4 pf req", bus.mem_req_o, 1);
    chk("t4 pf addr", bus.mem_addr_o, 17'h00022);
    next_cyc(); samp();
    chk("t4 branch stall", bus.stall_o, 1);
    next_cyc(); samp();
    chk("t4 lo ack addr", bus.mem_addr_o, 17'h00022);
    next_cyc(); samp();
    chk("t4 abort req", bus.mem_req_o, 0);
    chk("t4 abort stall", bus.stall_o, 1);
    ack_delay = 0;
    next_cyc(); samp();
    chk("t4 demand req", bus.mem_req_o, 1);
    chk("t4 demand addr", bus.mem_addr_o, 17'h01000);
    next_cyc(); next_cyc(); samp();
    chk("t4 0x800 stall", bus.stall_o, 0);
    chk("t4 0x800 inst", bus.inst_o, 32'h2A221911);
    next_cyc(); bus.fetch_addr_i = 16'h0010; samp();
    chk("t4 0x10 kept", bus.stall_o, 0);
    chk("t4 0x10 again", bus.inst_o, 32'h22321101);

    // 5: prefetch wraps from 0xFFFF to 0x0000
    do_reset(16'hFFFF);
    wait_hit(st);
    chk("t5 stalls", st, 3);
    chk("t5 inst", bus.inst_o, 32'hDDDDEEEE);
    next_cyc(); samp();
    chk("t5 wrap req", bus.mem_req_o, 1);
    chk("t5 wrap lo", bus.mem_addr_o, 17'h00000);
    next_cyc(); samp();
    chk("t5 wrap hi", bus.mem_addr_o, 17'h00001);
    next_cyc(); bus.fetch_addr_i = 16'h0000; samp();
    chk("t5 0 stall", bus.stall_o, 0);
    chk("t5 0 inst", bus.inst_o, 32'h22221111);

    // 6: reset during HI before its ack
    do_reset(16'h0020);
    wait_hit(st);
    chk("t6 0x20 inst", bus.inst_o, 32'h22021131);
    repeat (3) next_cyc();
    bus.fetch_addr_i = 16'h0040;
    ack_delay = 3;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      samp();
      if (bus.mem_req_o && bus.mem_addr_o[0]) done = 1'b1;
      else next_cyc();
    end
    chk("t6 reached HI", done, 1);
    chk("t6 HI ack", bus.mem_ack_i, 0);
    rst = 1'b0;
    #1;
    chk("t6 rst req", bus.mem_req_o, 0);
    chk("t6 rst 0x40", bus.stall_o, 1);
    bus.fetch_addr_i = 16'h0020; #1;
    chk("t6 rst 0x20", bus.stall_o, 1);
    bus.fetch_addr_i = 16'h0021; #1;
    chk("t6 rst 0x21", bus.stall_o, 1);
    chk("t6 rst inst", bus.inst_o, 0);
    do_reset(16'h0040);
    wait_hit(st);
    chk("t6 refetch stalls", st, 3);
    chk("t6 refetch inst", bus.inst_o, 32'h22621151);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
